// File: rtl/pwm_mc_pkg.sv
// Shared types and helpers for the multi-channel H-bridge PWM (pwm_hbridge_mc).
// Duty saturation and ramp arithmetic live here so every channel computes them identically.
package pwm_mc_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } ch_state_e;

    localparam int DEAD_DEFAULT = 4;

    // Dead counter width; a zero dead-time still needs a one-bit counter to exist.
    function automatic int dead_w(input int dead);
        return (dead > 0) ? $clog2(dead + 1) : 1;
    endfunction

    localparam int DW = dead_w(DEAD_DEFAULT);

    function automatic int sat_duty(input int speed, input int period);
        return (speed > period) ? period : speed;
    endfunction

    function automatic int ramp_toward(input int cur, input int tgt, input int step);
        if (tgt > cur)
            return ((tgt - cur) > step) ? cur + step : tgt;
        else
            return ((cur - tgt) > step) ? cur - step : tgt;
    endfunction

endpackage

// File: rtl/pwm_mc_channel.sv
// One H-bridge channel: double-buffered duty/direction, RUN/DEAD FSM with dead counter,
// registered compare against the shared counter, and duty slewing when SLEW_RAMP_EN is defined.
module pwm_mc_channel
    import pwm_mc_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int PERIOD = 100,
    parameter int DEAD   = 4,
    parameter int STEP   = 5
) (
    input  logic             clk_10k,
    input  logic             rst_n,
    input  logic             en,
    input  logic             en_rise,
    input  logic             boundary,
    input  logic [CNT_W-1:0] next_cnt,
    input  logic [CNT_W-1:0] speed_i,
    input  logic             dir_i,
    output logic             pwml,
    output logic             pwmr,
    output logic             dead_active
);

    localparam int DCW = dead_w(DEAD);
`ifdef SLEW_RAMP_EN
    localparam int MAX_STEP = STEP;
`else
    // Any step of at least PERIOD turns the ramp into a jump to the target.
    localparam int MAX_STEP = (STEP > PERIOD) ? STEP : PERIOD;
`endif

    ch_state_e        state_q, state_d;
    logic [DCW-1:0]   dead_cnt_q, dead_cnt_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             dir_q, dir_d;
    logic             pwml_q, pwml_d;
    logic             pwmr_q, pwmr_d;
    logic [CNT_W-1:0] target;
    logic             hi;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_10k) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            dead_cnt_q <= '0;
            duty_q     <= '0;
            dir_q      <= 1'b1;
            pwml_q     <= 1'b0;
            pwmr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dead_cnt_q <= dead_cnt_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            pwml_q     <= pwml_d;
            pwmr_q     <= pwmr_d;
        end
    end

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        duty_d     = duty_q;
        dir_d      = dir_q;
        target     = CNT_W'(sat_duty(int'(speed_i), PERIOD));
        if (!en) begin
            state_d    = ST_RUN;
            dead_cnt_d = '0;
        end else if (en_rise) begin
            // Bridge was idle while disabled, so the reload needs no dead-time.
            state_d = ST_RUN;
            duty_d  = target;
            dir_d   = dir_i;
        end else if (boundary) begin
            if (dir_i != dir_q) begin
`ifdef SLEW_RAMP_EN
                if (duty_q != '0) begin
                    duty_d = CNT_W'(ramp_toward(int'(duty_q), 0, MAX_STEP));
                end else begin
                    dir_d  = dir_i;
                    duty_d = CNT_W'(ramp_toward(0, int'(target), MAX_STEP));
                    if (DEAD > 0) begin
                        state_d    = ST_DEAD;
                        dead_cnt_d = DCW'(DEAD - 1);
                    end
                end
`else
                dir_d  = dir_i;
                duty_d = target;
                if (DEAD > 0) begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = DCW'(DEAD - 1);
                end
`endif
            end else begin
                duty_d = CNT_W'(ramp_toward(int'(duty_q), int'(target), MAX_STEP));
            end
        end else if (state_q == ST_DEAD) begin
            if (dead_cnt_q == '0)
                state_d = ST_RUN;
            else
                dead_cnt_d = dead_cnt_q - DCW'(1);
        end
    end

    // Compare against next_cnt so the registered outputs line up with the counter value.
    always_comb begin
        pwml_d = 1'b0;
        pwmr_d = 1'b0;
        hi     = next_cnt < duty_d;
        if (en && state_d == ST_RUN) begin
            if (dir_d)
                pwml_d = hi;
            else
                pwmr_d = hi;
        end
    end

    assign pwml        = pwml_q;
    assign pwmr        = pwmr_q;
    assign dead_active = (state_q == ST_DEAD);

endmodule

// File: rtl/pwm_hbridge_mc.sv
// Multi-channel H-bridge PWM top: shared period counter, period_start pulse, CH channel instances.
// Optional duty slewing is enabled by defining the macro SLEW_RAMP_EN.
module pwm_hbridge_mc
    import pwm_mc_pkg::*;
#(
    parameter int CH     = 2,
    parameter int CNT_W  = 8,
    parameter int PERIOD = 100,
    parameter int DEAD   = DEAD_DEFAULT,
    parameter int STEP   = 5
) (
    input  logic                clk_10k,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CH*CNT_W-1:0] speed,
    input  logic [CH-1:0]       direction,
    output logic [CH-1:0]       pwml,
    output logic [CH-1:0]       pwmr,
    output logic                period_start,
    output logic [CH-1:0]       dead_active
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             period_start_q, period_start_d;
    logic             en_rise;
    logic             boundary;

    always_ff @(posedge clk_10k) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            en_q           <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            en_q           <= en_d;
            period_start_q <= period_start_d;
        end
    end

    // The enabling edge keeps cnt at 0 so the first enabled period is a full one.
    always_comb begin
        en_rise        = en && !en_q;
        boundary       = en && (cnt_q == CNT_W'(PERIOD - 1));
        en_d           = en;
        cnt_d          = cnt_q + CNT_W'(1);
        if (!en || en_rise || boundary)
            cnt_d = '0;
        period_start_d = en && (cnt_d == '0);
    end

    assign period_start = period_start_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pwm_mc_channel #(
            .CNT_W  (CNT_W),
            .PERIOD (PERIOD),
            .DEAD   (DEAD),
            .STEP   (STEP)
        ) u_ch (
            .clk_10k     (clk_10k),
            .rst_n       (rst_n),
            .en          (en),
            .en_rise     (en_rise),
            .boundary    (boundary),
            .next_cnt    (cnt_d),
            .speed_i     (speed[i*CNT_W +: CNT_W]),
            .dir_i       (direction[i]),
            .pwml        (pwml[i]),
            .pwmr        (pwmr[i]),
            .dead_active (dead_active[i])
        );
    end

endmodule
